// File: rtl/filter_moving_avg_pkg.sv
// Shared math helpers for the moving-average filter slice.
package filter_moving_avg_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(64) = 6, clog2(65) = 7.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/filter_moving_avg_delay.sv
// Parameterised valid+data shift delay. Valid and data bits are cleared
// synchronously on reset. Each data stage only loads when the stage
// before it holds a valid entry, so the output holds its last value
// while o_valid is low.
module filter_moving_avg_delay
  import filter_moving_avg_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_valid = i_valid;
      assign o_data  = i_data;
    end else begin : g_shift
      logic [DEPTH-1:0] r_valid;
      logic [WIDTH-1:0] r_data [DEPTH];

      // Shift valid every cycle; move data only behind a valid entry.
      always_ff @(posedge Clk) begin
        if (Rst) begin
          r_valid <= '0;
          for (int unsigned i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
          end
        end else begin
          r_valid[0] <= i_valid;
          if (i_valid) begin
            r_data[0] <= i_data;
          end
          for (int unsigned i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            if (r_valid[i-1]) begin
              r_data[i] <= r_data[i-1];
            end
          end
        end
      end

      assign o_valid = r_valid[DEPTH-1];
      assign o_data  = r_data[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/filter_moving_avg.sv
// Streaming boxcar filter: running sum of the last WINDOW_LENGTH unsigned
// samples, reported as the top OUTPUT_WIDTH bits of the accumulator.
// Two arithmetic stages, then a valid/data delay line pads to LATENCY.
// Optional macro FILTER_MOVING_AVG_ROUND_EN: round-half-up with
// saturation instead of plain truncation (same latency).
module filter_moving_avg
  import filter_moving_avg_pkg::*;
#(
  parameter int unsigned WINDOW_LENGTH = 64,
  parameter int unsigned LATENCY       = 65,
  parameter int unsigned INPUT_WIDTH   = 14,
  parameter int unsigned OUTPUT_WIDTH  = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Input_valid,
  input  logic [INPUT_WIDTH-1:0]  Input_data,
  output logic                    Output_valid,
  output logic [OUTPUT_WIDTH-1:0] Output_data
);

  localparam int unsigned ACCUM_WIDTH = INPUT_WIDTH + clog2(WINDOW_LENGTH);
  localparam int unsigned IDX_WIDTH   = clog2(WINDOW_LENGTH);
  localparam int unsigned FILL_WIDTH  = clog2(WINDOW_LENGTH + 1);
  localparam int unsigned PIPE_DEPTH  = 2;
  localparam int unsigned PAD_DEPTH   = LATENCY - PIPE_DEPTH;
  localparam int unsigned SHIFT       = ACCUM_WIDTH - OUTPUT_WIDTH;

  logic [INPUT_WIDTH-1:0]  r_hist [WINDOW_LENGTH];
  logic [IDX_WIDTH-1:0]    r_wptr;
  logic [FILL_WIDTH-1:0]   r_fill;
  logic                    w_full;

  logic                    r_s1_valid;
  logic [INPUT_WIDTH-1:0]  r_s1_new;
  logic [INPUT_WIDTH-1:0]  r_s1_old;

  logic [ACCUM_WIDTH-1:0]  r_accum;
  logic [ACCUM_WIDTH-1:0]  w_accum_next;
  logic [OUTPUT_WIDTH-1:0] w_result;
  logic                    r_s2_valid;
  logic [OUTPUT_WIDTH-1:0] r_s2_data;

  // Until the window has filled once, the slot being replaced is treated
  // as zero, so the history RAM never needs clearing.
  assign w_full = (r_fill == FILL_WIDTH'(WINDOW_LENGTH));

  // History RAM: write the new sample into the slot being retired.
  always_ff @(posedge Clk) begin
    if (!Rst && Input_valid) begin
      r_hist[r_wptr] <= Input_data;
    end
  end

  // Stage 1: capture new sample and the retiring one (read-before-write
  // on the same edge), advance pointer and saturating fill count.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wptr     <= '0;
      r_fill     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_new   <= '0;
      r_s1_old   <= '0;
    end else begin
      r_s1_valid <= Input_valid;
      if (Input_valid) begin
        r_s1_new <= Input_data;
        r_s1_old <= w_full ? r_hist[r_wptr] : '0;
        r_wptr   <= (r_wptr == IDX_WIDTH'(WINDOW_LENGTH - 1)) ? '0
                                                              : r_wptr + IDX_WIDTH'(1);
        if (!w_full) begin
          r_fill <= r_fill + FILL_WIDTH'(1);
        end
      end
    end
  end

`ifdef FILTER_MOVING_AVG_ROUND_EN
  localparam logic [ACCUM_WIDTH:0] ROUND_ADD =
    (SHIFT == 0) ? '0 : ((ACCUM_WIDTH+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0));
  localparam logic [ACCUM_WIDTH:0] OUT_MAX = (ACCUM_WIDTH+1)'({OUTPUT_WIDTH{1'b1}});
  logic [ACCUM_WIDTH:0] w_rounded;
  logic [ACCUM_WIDTH:0] w_scaled;

  // Running-sum update, then round-half-up with saturation.
  always_comb begin
    w_accum_next = r_accum + ACCUM_WIDTH'(r_s1_new) - ACCUM_WIDTH'(r_s1_old);
    w_rounded    = {1'b0, w_accum_next} + ROUND_ADD;
    w_scaled     = w_rounded >> SHIFT;
    w_result     = (w_scaled > OUT_MAX) ? '1 : OUTPUT_WIDTH'(w_scaled);
  end
`else
  // Running-sum update, then truncation to the top OUTPUT_WIDTH bits.
  always_comb begin
    w_accum_next = r_accum + ACCUM_WIDTH'(r_s1_new) - ACCUM_WIDTH'(r_s1_old);
    w_result     = OUTPUT_WIDTH'(w_accum_next >> SHIFT);
  end
`endif

  // Stage 2: commit the accumulator and register the scaled result.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_accum    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_accum   <= w_accum_next;
        r_s2_data <= w_result;
      end
    end
  end

  filter_moving_avg_delay #(
    .DEPTH (PAD_DEPTH),
    .WIDTH (OUTPUT_WIDTH)
  ) u_delay (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_valid (r_s2_valid),
    .i_data  (r_s2_data),
    .o_valid (Output_valid),
    .o_data  (Output_data)
  );

endmodule

// File: tb/tb_filter_moving_avg.sv
// Directed-vector bench for filter_moving_avg (default parameters),
// with a 64-deep window-sum model for the randomised stretches.
module tb_filter_moving_avg;

`ifdef FILTER_MOVING_AVG_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Input_valid;
  logic [13:0] Input_data;
  logic        Output_valid;
  logic [15:0] Output_data;

  always #5 Clk = ~Clk;

  filter_moving_avg #(
    .WINDOW_LENGTH (64),
    .LATENCY       (65),
    .INPUT_WIDTH   (14),
    .OUTPUT_WIDTH  (16)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Input_valid  (Input_valid),
    .Input_data   (Input_data),
    .Output_valid (Output_valid),
    .Output_data  (Output_data)
  );

  typedef struct {
    int unsigned exp;
    int unsigned cyc;
  } exp_t;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned cyc     = 0;
  logic        rst_q   = 1'b0;
  exp_t        exp_q[$];
  int unsigned win[$];

  always @(posedge Clk) begin
    cyc   <= cyc + 1;
    rst_q <= Rst;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned scale(input int unsigned sum);
    int unsigned r;
    if (ROUND) begin
      r = (sum + 8) >> 4;
      if (r > 16'hFFFF) r = 16'hFFFF;
    end else begin
      r = sum >> 4;
    end
    return r;
  endfunction

  function automatic int unsigned model_push(input int unsigned d);
    int unsigned sum;
    win.push_back(d);
    if (win.size() > 64) void'(win.pop_front());
    sum = 0;
    foreach (win[i]) sum += win[i];
    return scale(sum);
  endfunction

  // One-cycle sample; use_hand selects a hand-computed expectation.
  task automatic send(input logic [13:0] d, input bit use_hand, input int unsigned hand);
    int unsigned m;
    exp_t e;
    m = model_push(d);
    e.exp = use_hand ? hand : m;
    e.cyc = cyc;
    exp_q.push_back(e);
    Input_valid = 1'b1;
    Input_data  = d;
    @(posedge Clk);
    #1;
    Input_valid = 1'b0;
    Input_data  = 'x;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Reset with a valid strobe held high; those samples must be ignored.
  task automatic reset_dut();
    Rst         = 1'b1;
    Input_valid = 1'b1;
    Input_data  = 14'h3FFF;
    @(posedge Clk);
    #1;
    exp_q.delete();
    win.delete();
    idle(3);
    Rst         = 1'b0;
    Input_valid = 1'b0;
    Input_data  = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge Clk);
      #1;
    end
    chk("drain_empty", exp_q.size(), 0);
    idle(3);
  endtask

  // Output monitor: order, data, exact latency, silence during reset.
  always @(negedge Clk) begin
    exp_t e;
    if (Output_valid !== 1'b0) begin
      chk("valid_in_reset", {31'd0, rst_q}, 0);
      chk("unexpected_out", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", {16'd0, Output_data}, e.exp);
        chk("latency", cyc - e.cyc, 65);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Rst         = 1'b0;
    Input_valid = 1'b0;
    Input_data  = '0;

    reset_dut();
    chk("rst_valid", {31'd0, Output_valid}, 0);
    chk("rst_data", {16'd0, Output_data}, 0);

    send(14'h0010, 1'b1, 32'h0001);
    drain();

    reset_dut();
    send(14'h3FFF, 1'b1, ROUND ? 32'h0400 : 32'h03FF);
    drain();

    reset_dut();
    send(14'h0008, 1'b1, ROUND ? 32'h0001 : 32'h0000);
    drain();

    // Back-to-back full-scale window, then one zero retires one sample.
    reset_dut();
    for (int k = 0; k < 63; k++) send(14'h3FFF, 1'b0, 0);
    send(14'h3FFF, 1'b1, 32'hFFFC);
    send(14'h0000, 1'b1, 32'hFBFC);
    drain();

    for (int run = 0; run < 3; run++) begin
      reset_dut();
      for (int k = 0; k < 400; k++) begin
        send(14'($urandom_range(0, 16383)), 1'b0, 0);
        idle($urandom_range(0, 5));
      end
      drain();
    end

    // Mid-stream reset discards in-flight results and clears history.
    reset_dut();
    for (int k = 0; k < 70; k++) send(14'h3FFF, 1'b0, 0);
    idle(20);
    reset_dut();
    chk("mid_rst_valid", {31'd0, Output_valid}, 0);
    chk("mid_rst_data", {16'd0, Output_data}, 0);
    idle(80);
    send(14'h0010, 1'b1, 32'h0001);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
